// File: rtl/xor_flip_pkg.sv
// Shared definitions for the XOR flip bank.
//   DEF_*       : default parameter values for the top and decoder
//   MAX_*       : upper bounds used to size the slot typedef and helper
//   idx_slot_t  : one bit-index slot, wide enough for the largest WIDTH
//   popcount_par: parity of an enable vector (odd count -> 1)
package xor_flip_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_NFLIP = 2;
  localparam int DEF_CNTW  = 16;
  localparam int MAX_NFLIP = 8;
  localparam int MAX_IDXW  = 8;

  typedef logic [MAX_IDXW-1:0] idx_slot_t;

  function automatic logic popcount_par(input logic [MAX_NFLIP-1:0] en);
    return ^en;
  endfunction
endpackage

// File: rtl/xor_flip_bank_if.sv
// Request channel of the XOR flip bank.
//   req_valid : request present          (master -> slave)
//   req_ready : request can be accepted  (slave -> master)
//   req_idx   : packed bit indices, slot k at [k*IDXW +: IDXW]
//   req_en    : per-slot enable
interface xor_flip_bank_if #(
  parameter int WIDTH = 32,
  parameter int NFLIP = 2
);
  localparam int IDXW = $clog2(WIDTH);

  logic                  req_valid;
  logic                  req_ready;
  logic [NFLIP*IDXW-1:0] req_idx;
  logic [NFLIP-1:0]      req_en;

  modport master (output req_valid, req_idx, req_en, input req_ready);
  modport slave  (input req_valid, req_idx, req_en, output req_ready);
endinterface

// File: rtl/xor_flip_dec.sv
// Combinational stage-1 decode for the flip bank.
//   idx_i  : packed slot indices
//   en_i   : per-slot enable
//   mask_o : OR of one-hot(idx) over enabled slots
//   dup_o  : two enabled slots carry the same index
//   npar_o : parity of the enabled-slot count
module xor_flip_dec
  import xor_flip_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NFLIP = DEF_NFLIP,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic [NFLIP*IDXW-1:0] idx_i,
  input  logic [NFLIP-1:0]      en_i,
  output logic [WIDTH-1:0]      mask_o,
  output logic                  dup_o,
  output logic                  npar_o
);
  idx_slot_t                       slot [NFLIP];
  logic [NFLIP-1:0][NFLIP-1:0]     pair_eq;

  for (genvar gk = 0; gk < NFLIP; gk++) begin : g_slot
    assign slot[gk] = idx_slot_t'(idx_i[gk*IDXW +: IDXW]);
  end

  // Upper triangle only: one comparator per unordered slot pair.
  for (genvar gi = 0; gi < NFLIP; gi++) begin : g_row
    for (genvar gj = 0; gj < NFLIP; gj++) begin : g_col
      if (gj > gi) begin : g_cmp
        assign pair_eq[gi][gj] = en_i[gi] & en_i[gj] & (slot[gi] == slot[gj]);
      end else begin : g_nil
        assign pair_eq[gi][gj] = 1'b0;
      end
    end
  end

  assign dup_o  = |pair_eq;
  assign npar_o = popcount_par(MAX_NFLIP'(en_i));

  always_comb begin
    mask_o = '0;
    for (int k = 0; k < NFLIP; k++)
      if (en_i[k]) mask_o[idx_i[k*IDXW +: IDXW]] = 1'b1;
  end
endmodule

// File: rtl/xor_flip_bank.sv
// XOR flip bank: a WIDTH-bit register whose bits are toggled by indexed
// requests through a two-stage pipeline, with parity tracking and counters.
//   clk, rst  : clock, async active-high reset
//   clr       : synchronous clear (q, parity state, pipeline; not counters)
//   req       : request channel (slave side)
//   q         : flip register
//   par_exp   : expected parity of q
//   par_err   : sticky parity mismatch flag
//   dup_err   : one-cycle pulse on a rejected (duplicate-index) request
//   flip_cnt  : applied requests, wraps
//   dup_cnt   : rejected requests, saturates
module xor_flip_bank
  import xor_flip_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int NFLIP = DEF_NFLIP,
  parameter  int CNTW  = DEF_CNTW,
  localparam int IDXW  = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  xor_flip_bank_if.slave    req,
  output logic [WIDTH-1:0]  q,
  output logic              par_exp,
  output logic              par_err,
  output logic              dup_err,
  output logic [CNTW-1:0]   flip_cnt,
  output logic [CNTW-1:0]   dup_cnt
);
  logic [NFLIP*IDXW-1:0] idx_w;
  logic [WIDTH-1:0]      dec_mask;
  logic                  dec_dup, dec_npar, accept, apply, reject;

  logic                  s1_vld_q, s1_vld_d, s1_dup_q, s1_dup_d, s1_par_q, s1_par_d;
  logic [WIDTH-1:0]      s1_mask_q, s1_mask_d, q_q, q_d;
  logic                  par_exp_q, par_exp_d, par_err_q, par_err_d, dup_err_q, dup_err_d;
  logic [CNTW-1:0]       flip_cnt_q, flip_cnt_d, dup_cnt_q, dup_cnt_d;

  assign req.req_ready = ~clr;
  assign accept        = req.req_valid & req.req_ready;
  assign idx_w         = req.req_idx;

  xor_flip_dec #(.WIDTH(WIDTH), .NFLIP(NFLIP)) u_dec (
    .idx_i (idx_w),
    .en_i  (req.req_en),
    .mask_o(dec_mask),
    .dup_o (dec_dup),
    .npar_o(dec_npar)
  );

  assign apply  = s1_vld_q & ~s1_dup_q;
  assign reject = s1_vld_q &  s1_dup_q;

  always_comb begin
    s1_vld_d   = accept;
    s1_mask_d  = dec_mask;
    s1_dup_d   = dec_dup;
    s1_par_d   = dec_npar;
    q_d        = apply ? (q_q ^ s1_mask_q) : q_q;
    par_exp_d  = par_exp_q ^ (apply & s1_par_q);
    // Compare the current register with its expected parity; latch on miss.
    par_err_d  = par_err_q | ((^q_q) ^ par_exp_q);
    dup_err_d  = reject;
    flip_cnt_d = flip_cnt_q + CNTW'(apply);
    dup_cnt_d  = (reject && !(&dup_cnt_q)) ? dup_cnt_q + 1'b1 : dup_cnt_q;
    if (clr) begin
      // In-flight work is discarded uncounted; counters keep history.
      s1_vld_d   = 1'b0;
      q_d        = '0;
      par_exp_d  = 1'b0;
      par_err_d  = 1'b0;
      dup_err_d  = 1'b0;
      flip_cnt_d = flip_cnt_q;
      dup_cnt_d  = dup_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_mask_q  <= '0;
      s1_dup_q   <= 1'b0;
      s1_par_q   <= 1'b0;
      q_q        <= '0;
      par_exp_q  <= 1'b0;
      par_err_q  <= 1'b0;
      dup_err_q  <= 1'b0;
      flip_cnt_q <= '0;
      dup_cnt_q  <= '0;
    end else begin
      s1_vld_q   <= s1_vld_d;
      s1_mask_q  <= s1_mask_d;
      s1_dup_q   <= s1_dup_d;
      s1_par_q   <= s1_par_d;
      q_q        <= q_d;
      par_exp_q  <= par_exp_d;
      par_err_q  <= par_err_d;
      dup_err_q  <= dup_err_d;
      flip_cnt_q <= flip_cnt_d;
      dup_cnt_q  <= dup_cnt_d;
    end
  end

  assign q        = q_q;
  assign par_exp  = par_exp_q;
  assign par_err  = par_err_q;
  assign dup_err  = dup_err_q;
  assign flip_cnt = flip_cnt_q;
  assign dup_cnt  = dup_cnt_q;
endmodule

// File: doc/xor_flip_bank.md
XOR_FLIP_BANK -- requirements
Module: xor_flip_bank

Interface
REQ-001 SHALL have parameter WIDTH, default 32, meaning register width; power of two, range 2..256.
REQ-002 SHALL have parameter NFLIP, default 2, meaning index slots per request; range 1..8.
REQ-003 SHALL have parameter CNTW, default 16, meaning width of the statistics counters.
REQ-004 SHALL derive localparam IDXW = $clog2(WIDTH).
REQ-005 SHALL have port `clk`, input, width 1: sole clock; all logic on its rising edge.
REQ-006 SHALL have port `rst`, input, width 1: asynchronous, active-high reset.
REQ-007 SHALL have port `clr`, input, width 1: synchronous clear command.
REQ-008 SHALL have port `req_valid`, input, width 1: flip request present.
REQ-009 SHALL have port `req_ready`, output, width 1: request can be accepted.
REQ-010 SHALL have port `req_idx`, input, width NFLIP*IDXW: packed bit indices; slot k occupies bits [k*IDXW +: IDXW].
REQ-011 SHALL have port `req_en`, input, width NFLIP: per-slot enable.
REQ-012 SHALL have port `q`, output, width WIDTH: flip register.
REQ-013 SHALL have port `par_exp`, output, width 1: expected parity of q.
REQ-014 SHALL have port `par_err`, output, width 1: sticky flag, set when ^q != par_exp.
REQ-015 SHALL have port `dup_err`, output, width 1: one-cycle pulse on a rejected request.
REQ-016 SHALL have port `flip_cnt`, output, width CNTW: number of applied requests.
REQ-017 SHALL have port `dup_cnt`, output, width CNTW: number of rejected requests.

Function
REQ-018 SHALL drive req_ready = !clr; a request is accepted when req_valid && req_ready.
REQ-019 SHALL run a two-stage pipeline.
- Stage 1 (edge after acceptance) registers a WIDTH-bit mask: OR of one-hot(req_idx[k]) over enabled slots.
- Stage 1 also registers a duplicate flag and the enabled-slot count parity.
REQ-020 SHALL set the duplicate flag when any two enabled slots carry equal indices; disabled slots are ignored.
REQ-021 SHALL, at stage 2 (second edge after acceptance), apply a non-duplicate request as follows.
- q <= q ^ mask.
- par_exp toggles iff the enabled-slot count is odd.
- flip_cnt increments, wrapping modulo 2^CNTW.
REQ-022 SHALL, at stage 2, handle a duplicate request as follows.
- Leave q and par_exp unchanged.
- Pulse dup_err high for exactly that cycle.
- Increment dup_cnt, saturating at all-ones.
REQ-023 SHALL accept a request with zero enabled slots: it counts in flip_cnt and leaves q and par_exp unchanged.
REQ-024 SHALL sustain back-to-back acceptance, one request per cycle, with no stall or bubble.
REQ-025 SHALL, on clr, at the next edge: zero q; clear par_exp and par_err; invalidate both pipeline stages (in-flight requests dropped, uncounted); leave counters unchanged.
REQ-026 SHALL set par_err on the edge after any cycle with ^q != par_exp; it holds until clr or rst.
REQ-027 SHALL treat an index ≥ WIDTH as impossible by construction, since WIDTH is a power of two.

Reset
REQ-028 SHALL, while rst is high and asynchronously: set q=0, par_exp=0, par_err=0, dup_err=0, flip_cnt=0, dup_cnt=0, and both pipeline valids=0.
REQ-029 SHALL drive req_ready high during reset; requests offered during reset are not accepted.
REQ-030 SHALL drop any in-flight request when reset is asserted mid-operation; the first request accepted after deassertion sees q=0.

Structure
REQ-031 SHALL place the following in package xor_flip_pkg:
- Default parameter constants.
- Index-slot typedef.
- Function popcount_par (parity of the enable vector).
REQ-032 SHALL implement stage-1 decode/duplicate-detect as sub-module xor_flip_dec: purely combinational, with NFLIP*(NFLIP-1)/2 pairwise comparators.

Verification
REQ-033 SHALL cover reset release then one request (idx {3,17}, en 2'b11) -> q=0x00020008 two cycles later; par_exp=0; flip_cnt=1.
REQ-034 SHALL cover request {5,5}, en 2'b11 -> q unchanged; dup_err pulses 1 cycle; dup_cnt=1; flip_cnt unchanged.
REQ-035 SHALL cover request {9,5}, en 2'b01 -> q bit 9 toggles; par_exp toggles to 1; no dup despite slot 1 holding 5.
REQ-036 SHALL cover 4 back-to-back requests {0,1},{1,2},{2,3},{3,0} -> q=0 afterwards; flip_cnt=4; par_err stays 0.
REQ-037 SHALL cover clr asserted while 2 requests are in flight -> q=0; in-flight requests lost; flip_cnt unchanged; req_ready=0 that cycle.
REQ-038 SHALL cover flip_cnt preloaded via 2^CNTW-1 requests plus one more -> flip_cnt wraps to 0; dup_cnt saturation is checked likewise.
